// File: rtl/alu_multi_cycle_if.sv
// Start/done bus between the ALU bus-functional driver and the multi-cycle ALU.
interface alu_multi_cycle_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         opcode;
  logic               start;
  logic               busy;
  logic               done_aax;
  logic               err_aax;
  logic [2*WIDTH-1:0] result_aax;

  modport master (
    output A, B, opcode, start,
    input  busy, done_aax, err_aax, result_aax
  );

  modport slave (
    input  A, B, opcode, start,
    output busy, done_aax, err_aax, result_aax
  );
endinterface

// File: rtl/alu_multi_cycle.sv
// Multi-cycle ALU: single-cycle ADD/AND/XOR, iterative shift-add MUL, illegal-opcode flag.
//   state  | meaning
//   S_IDLE | ready; accepts start, single-cycle ops complete from here
//   S_MUL  | shift-add multiply iterating, one multiplier bit per cycle
module alu_multi_cycle #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_multi_cycle_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100
  } opcode_t;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sum      = {1'b0, bus.A} + {1'b0, bus.B};
    acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.opcode)
            OP_NOP: result_d = '0;
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, sum};
              done_d   = 1'b1;
            end
            OP_AND: begin
              result_d = {{WIDTH{1'b0}}, bus.A & bus.B};
              done_d   = 1'b1;
            end
            OP_XOR: begin
              result_d = {{WIDTH{1'b0}}, bus.A ^ bus.B};
              done_d   = 1'b1;
            end
            OP_MUL: begin
              mcand_d  = {{WIDTH{1'b0}}, bus.A};
              mplier_d = bus.B;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            default: begin
              result_d = '0;
              done_d   = 1'b1;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // busy drops in the same cycle done rises, so the final iteration clears it
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = acc_step;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          busy_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done_aax   = done_q;
  assign bus.err_aax    = err_q;
  assign bus.result_aax = result_q;
endmodule

// File: doc/alu_multi_cycle.md
Name: alu_multi_cycle

Overview:
- Parametrised successor to the single-cycle ALU datapath.
- Generalises operand width and adds an iterative shift-add multiply (OP_MUL) with a busy/done handshake.
- Adds an illegal-opcode error flag.
- Sits between the ALU bus-functional interface and the result checker, using the same start/done protocol as the existing single-cycle block.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived, do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- A  input  WIDTH  operand A, sampled when start accepted
- B  input  WIDTH  operand B, sampled when start accepted
- opcode  input  3 (OPCODE_T)  operation, sampled when start accepted
- start  input  1  request; accepted only when busy=0
- busy  output  1  multiply in progress
- done_aax  output  1  one-cycle pulse: result_aax valid
- err_aax  output  1  one-cycle pulse with done_aax: illegal opcode
- result_aax  output  2*WIDTH  result; holds until next accepted start

Behaviour:
- Opcode encoding:
  - OP_NOP=000, OP_ADD=001, OP_AND=010, OP_XOR=011, OP_MUL=100.
  - 101..111 are illegal.
- Reset (reset=1 at a rising edge): busy=0, done_aax=0, err_aax=0, result_aax=0, state=IDLE, counter=0, internal operand registers=0. Reset wins over everything, including mid-multiply; no done is produced for an aborted operation.
- Accept: start=1 while state=IDLE at a rising edge. Start while busy=1 is ignored with no side effects.
- ADD/AND/XOR: 1-cycle latency.
  - result_aax = zero-extended A op B; for ADD, bit WIDTH is the carry.
  - done_aax=1 in the cycle after accept. State stays IDLE, so back-to-back starts on consecutive cycles each produce a done.
- NOP with start: result_aax <= 0, done_aax stays 0, err_aax stays 0.
- Illegal opcode with start: result_aax <= 0, done_aax=1 and err_aax=1 for one cycle (1-cycle latency).
- MUL: FSM IDLE -> MUL -> IDLE.
  - On accept: capture A into the multiplicand register and B into the multiplier register, clear the 2*WIDTH accumulator, set counter=0, state=MUL. busy=1 from the next cycle.
  - Each cycle in MUL: if multiplier LSB=1, accumulator += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++.
  - On the iteration where counter=WIDTH-1: result_aax <= final accumulator, done_aax <= 1, state <= IDLE.
  - Latency: done_aax is high exactly WIDTH cycles after the accept edge (8 for WIDTH=8). busy is high for WIDTH-1 cycles and is 0 in the done cycle.
  - A start in the done cycle is accepted.
  - The product is unsigned and exact in 2*WIDTH bits; no overflow is possible.
- result_aax changes only on an accepted start (non-MUL ops) or on MUL completion. During MUL it keeps the previous value.
- done_aax and err_aax are never high for two consecutive cycles from the same operation.
- A, B and opcode are don't-care while busy=1.

Test Plan:
1. WIDTH=8, reset then ADD A=255 B=255 -> done_aax=1 one cycle later, result_aax=0x01FE, err_aax=0.
2. WIDTH=8, MUL A=255 B=255 -> busy=1 for 7 cycles, done_aax exactly 8 cycles after accept, result_aax=0xFE01. Repeat with A=0 B=200 -> result_aax=0.
3. WIDTH=8, back-to-back:
   - AND 0xF0,0x3C on cycle n -> 0x0030 at n+1.
   - XOR 0xF0,0x3C on cycle n+1 -> 0x00CC at n+2.
   - Two consecutive done pulses.
4. WIDTH=8, MUL 12*13 started, then start=1 with ADD 1+1 on cycles 2-4 -> ADD ignored, single done at cycle 8, result_aax=156.
5. WIDTH=8, MUL started, reset asserted for one cycle at cycle 4 -> all outputs 0 next cycle, no done_aax ever; then opcode=101 with start -> done_aax=1, err_aax=1, result_aax=0. NOP with start -> no done, result_aax=0.
6. WIDTH=16: MUL 0xFFFF*0xFFFF -> done at cycle 16, result_aax=0xFFFE0001. ADD 0xFFFF+1 -> result_aax=0x10000 after 1 cycle.
